// File: rtl/pkg_config.sv
// Project-wide configuration shared by the fetch/execute datapath blocks.
package pkg_config;
  localparam int DATA_WIDTH = 32;
endpackage

// File: rtl/branch_predictor.sv
// Direct-mapped branch target/direction predictor with zero-latency lookup and registered training.
// Optional same-cycle forwarding of a training write into the lookup path: define BP_BYPASS_EN.
module branch_predictor
  import pkg_config::*;
#(
  parameter int ENTRIES = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [DATA_WIDTH-1:0] pc_i,
  output logic                  pred_hit_o,
  output logic                  pred_taken_o,
  output logic [DATA_WIDTH-1:0] pred_target_o,
  input  logic                  upd_valid_i,
  input  logic [DATA_WIDTH-1:0] upd_pc_i,
  input  logic                  upd_taken_i,
  input  logic [DATA_WIDTH-1:0] upd_target_i,
  input  logic                  upd_pred_taken_i,
  input  logic [DATA_WIDTH-1:0] upd_pred_target_i,
  input  logic                  flush_i,
  output logic                  mispredict_o
);
  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_W = DATA_WIDTH - IDX_W - 2;
  localparam logic [DATA_WIDTH-1:0] PC_STEP = DATA_WIDTH'(4);

  logic [ENTRIES-1:0]    valid_q;
  logic [TAG_W-1:0]      tag_q    [ENTRIES];
  logic [DATA_WIDTH-1:0] target_q [ENTRIES];
  logic [1:0]            ctr_q    [ENTRIES];
  logic                  mispredict_q;

  logic [IDX_W-1:0] look_idx;
  logic [IDX_W-1:0] upd_idx;
  logic [TAG_W-1:0] look_tag;
  logic [TAG_W-1:0] upd_tag;
  logic             unused_pc_bits;

  assign look_idx       = pc_i[IDX_W+1:2];
  assign look_tag       = pc_i[DATA_WIDTH-1:IDX_W+2];
  assign upd_idx        = upd_pc_i[IDX_W+1:2];
  assign upd_tag        = upd_pc_i[DATA_WIDTH-1:IDX_W+2];
  assign unused_pc_bits = ^upd_pc_i[1:0];

  // Post-update image of the entry addressed by upd_pc_i; upd_write says whether it is stored.
  logic                  upd_hit;
  logic                  upd_write;
  logic [1:0]            new_ctr;
  logic [DATA_WIDTH-1:0] new_target;

  always_comb begin
    upd_hit    = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag);
    upd_write  = 1'b0;
    new_ctr    = ctr_q[upd_idx];
    new_target = target_q[upd_idx];
    if (upd_valid_i) begin
      if (upd_hit) begin
        upd_write = 1'b1;
        if (upd_taken_i) begin
          new_ctr    = (ctr_q[upd_idx] == 2'b11) ? 2'b11 : ctr_q[upd_idx] + 2'd1;
          new_target = upd_target_i;
        end else begin
          new_ctr = (ctr_q[upd_idx] == 2'b00) ? 2'b00 : ctr_q[upd_idx] - 2'd1;
        end
      end else if (upd_taken_i) begin
        upd_write  = 1'b1;
        new_ctr    = 2'b10;
        new_target = upd_target_i;
      end
    end
  end

  logic                  look_hit;
  logic [1:0]            look_ctr;
  logic [DATA_WIDTH-1:0] look_target;

  always_comb begin
    look_hit    = valid_q[look_idx] && (tag_q[look_idx] == look_tag);
    look_ctr    = ctr_q[look_idx];
    look_target = target_q[look_idx];
`ifdef BP_BYPASS_EN
    if (upd_write && !flush_i && (upd_idx == look_idx) && (upd_tag == look_tag)) begin
      look_hit    = 1'b1;
      look_ctr    = new_ctr;
      look_target = new_target;
    end
`endif
  end

  assign pred_hit_o    = look_hit;
  assign pred_taken_o  = look_hit && look_ctr[1];
  assign pred_target_o = pred_taken_o ? look_target : pc_i + PC_STEP;
  assign mispredict_o  = mispredict_q;

  // Flush wins over a same-cycle training write, but the mispredict flag still reports it.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q      <= '0;
      mispredict_q <= 1'b0;
      for (int i = 0; i < ENTRIES; i++) begin
        ctr_q[i]    <= 2'b01;
        target_q[i] <= '0;
        tag_q[i]    <= '0;
      end
    end else begin
      mispredict_q <= upd_valid_i &&
                      ((upd_pred_taken_i != upd_taken_i) ||
                       (upd_taken_i && (upd_pred_target_i != upd_target_i)));
      if (flush_i) begin
        valid_q <= '0;
      end else if (upd_write) begin
        valid_q[upd_idx]  <= 1'b1;
        tag_q[upd_idx]    <= upd_tag;
        ctr_q[upd_idx]    <= new_ctr;
        target_q[upd_idx] <= new_target;
      end
    end
  end
endmodule

// File: tb/tb_branch_predictor.sv
// Directed-vector bench for branch_predictor: drivers queue expected lookup/mispredict values,
// a negedge monitor pops and compares them.
module tb_branch_predictor;
  import pkg_config::*;
  localparam int DW = DATA_WIDTH;
  localparam int W  = DW + 3;

  logic          clk = 1'b0;
  logic          rst_i = 1'b1;
  logic [DW-1:0] pc_i = '0;
  logic          pred_hit_o;
  logic          pred_taken_o;
  logic [DW-1:0] pred_target_o;
  logic          upd_valid_i = 1'b0;
  logic [DW-1:0] upd_pc_i = '0;
  logic          upd_taken_i = 1'b0;
  logic [DW-1:0] upd_target_i = '0;
  logic          upd_pred_taken_i = 1'b0;
  logic [DW-1:0] upd_pred_target_i = '0;
  logic          flush_i = 1'b0;
  logic          mispredict_o;

  branch_predictor #(.ENTRIES(16)) dut (
    .clk_i(clk), .rst_i(rst_i), .pc_i(pc_i),
    .pred_hit_o(pred_hit_o), .pred_taken_o(pred_taken_o), .pred_target_o(pred_target_o),
    .upd_valid_i(upd_valid_i), .upd_pc_i(upd_pc_i), .upd_taken_i(upd_taken_i),
    .upd_target_i(upd_target_i), .upd_pred_taken_i(upd_pred_taken_i),
    .upd_pred_target_i(upd_pred_target_i), .flush_i(flush_i), .mispredict_o(mispredict_o)
  );

  // Clock / reset
  always #5 clk = ~clk;

  // Scoreboard state: packed {hit, taken, mispredict, target}
  logic [W-1:0] exp_q[$];
  string        name_q[$];
  logic         obs_valid = 1'b0;
  int           n_cmp = 0;
  int           n_fail = 0;

  // Drivers: one call = one cycle of inputs, applied just after the rising edge.
  task automatic drive(input string nm, input logic [DW-1:0] pc,
                       input logic uv, input logic [DW-1:0] upc, input logic ut,
                       input logic [DW-1:0] utgt, input logic upt, input logic [DW-1:0] uptgt,
                       input logic fl, input logic rs, input logic chk,
                       input logic e_hit, input logic e_taken, input logic [DW-1:0] e_tgt,
                       input logic e_mp);
    @(posedge clk);
    #1;
    pc_i = pc; upd_valid_i = uv; upd_pc_i = upc; upd_taken_i = ut; upd_target_i = utgt;
    upd_pred_taken_i = upt; upd_pred_target_i = uptgt; flush_i = fl; rst_i = rs;
    if (chk) begin
      exp_q.push_back({e_hit, e_taken, e_mp, e_tgt});
      name_q.push_back(nm);
    end
    obs_valid = chk;
  endtask

  task automatic look(input string nm, input logic [DW-1:0] pc, input logic e_hit,
                      input logic e_taken, input logic [DW-1:0] e_tgt, input logic e_mp);
    drive(nm, pc, 1'b0, '0, 1'b0, '0, 1'b0, '0, 1'b0, 1'b0, 1'b1, e_hit, e_taken, e_tgt, e_mp);
  endtask

  // Monitor
  always @(negedge clk) begin
    if (obs_valid) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL underflow: output presented with empty expected queue");
      end else begin
        logic [W-1:0] exp_v;
        logic [W-1:0] act_v;
        string        nm;
        exp_v = exp_q.pop_front();
        nm    = name_q.pop_front();
        act_v = {pred_hit_o, pred_taken_o, mispredict_o, pred_target_o};
        n_cmp++;
        if (act_v !== exp_v) begin
          n_fail++;
          $display("FAIL %s: got hit=%b taken=%b mp=%b tgt=%h, expected hit=%b taken=%b mp=%b tgt=%h",
                   nm, act_v[W-1], act_v[W-2], act_v[W-3], act_v[DW-1:0],
                   exp_v[W-1], exp_v[W-2], exp_v[W-3], exp_v[DW-1:0]);
        end
      end
    end
  end

  initial begin
    // reset, then empty-table lookup
    drive("rst", 32'h100, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
    look ("reset_lookup", 32'h100, 0, 0, 32'h104, 0);
    drive("alloc", 32'h104, 1, 32'h100, 1, 32'h80, 0, 0, 0, 0, 1, 0, 0, 32'h108, 0);
    look ("alloc_hit", 32'h100, 1, 1, 32'h80, 1);
    // counter walk 10 -> 01 -> 00 -> 00 -> 01 -> 10 -> 11 -> 11 -> 10
    drive("dec_10_01", 32'h100, 1, 32'h100, 0, 0, 1, 32'h80, 0, 0, 1, 1, 1, 32'h80, 0);
    drive("dec_01_00", 32'h100, 1, 32'h100, 0, 0, 0, 0, 0, 0, 1, 1, 0, 32'h104, 1);
    drive("dec_sat00", 32'h100, 1, 32'h100, 0, 0, 0, 0, 0, 0, 1, 1, 0, 32'h104, 0);
    look ("at_00", 32'h100, 1, 0, 32'h104, 0);
    drive("inc_00_01", 32'h100, 1, 32'h100, 1, 32'h80, 0, 32'h104, 0, 0, 1, 1, 0, 32'h104, 0);
    drive("inc_01_10", 32'h100, 1, 32'h100, 1, 32'h88, 0, 32'h104, 0, 0, 1, 1, 0, 32'h104, 1);
    drive("inc_10_11", 32'h100, 1, 32'h100, 1, 32'h88, 1, 32'h80, 0, 0, 1, 1, 1, 32'h88, 1);
    drive("inc_sat11", 32'h100, 1, 32'h100, 1, 32'h88, 1, 32'h88, 0, 0, 1, 1, 1, 32'h88, 1);
    drive("dec_11_10", 32'h100, 1, 32'h100, 0, 0, 1, 32'h88, 0, 0, 1, 1, 1, 32'h88, 0);
    look ("at_10", 32'h100, 1, 1, 32'h88, 1);
    // aliasing on index 0
    drive("alias_upd", 32'h100, 1, 32'h140, 1, 32'h200, 0, 0, 0, 0, 1, 1, 1, 32'h88, 0);
    look ("alias_old_gone", 32'h100, 0, 0, 32'h104, 1);
    drive("alias_new_nt_miss", 32'h140, 1, 32'h100, 0, 0, 0, 0, 0, 0, 1, 1, 1, 32'h200, 0);
    look ("nt_miss_no_alloc_a", 32'h140, 1, 1, 32'h200, 0);
    drive("nt_miss_no_alloc_b", 32'h100, 1, 32'h143, 1, 32'h204, 1, 32'h200, 0, 0, 1, 0, 0, 32'h104, 0);
    look ("low_bits_ignored", 32'h142, 1, 1, 32'h204, 1);
    // flush beats a same-cycle update
    drive("flush_with_upd", 32'h140, 1, 32'h180, 1, 32'h300, 0, 0, 1, 0, 1, 1, 1, 32'h204, 0);
    look ("flush_0x100", 32'h100, 0, 0, 32'h104, 1);
    look ("flush_0x140", 32'h140, 0, 0, 32'h144, 0);
    look ("flush_0x180", 32'h180, 0, 0, 32'h184, 0);
    look ("pc_wrap", 32'hFFFF_FFFC, 0, 0, 32'h0, 0);
    // reset mid-operation discards in-flight update
    drive("pre_rst_alloc", 32'h180, 1, 32'h104, 1, 32'h40, 0, 0, 0, 0, 1, 0, 0, 32'h184, 0);
    drive("rst_mid", 32'h104, 1, 32'h108, 1, 32'h50, 0, 0, 0, 1, 1, 1, 1, 32'h40, 1);
    look ("after_rst_a", 32'h104, 0, 0, 32'h108, 0);
    look ("after_rst_b", 32'h108, 0, 0, 32'h10C, 0);
    // same-cycle update and lookup
`ifdef BP_BYPASS_EN
    drive("same_cycle", 32'h300, 1, 32'h300, 1, 32'h10, 0, 0, 0, 0, 1, 1, 1, 32'h10, 0);
`else
    drive("same_cycle", 32'h300, 1, 32'h300, 1, 32'h10, 0, 0, 0, 0, 1, 0, 0, 32'h304, 0);
`endif
    look ("same_cycle_next", 32'h300, 1, 1, 32'h10, 1);
    drive("flush_no_fwd", 32'h300, 1, 32'h300, 1, 32'h20, 1, 32'h10, 1, 0, 1, 1, 1, 32'h10, 0);
    look ("flush_no_fwd_next", 32'h300, 0, 0, 32'h304, 1);
    drive("nt_miss_no_fwd", 32'h308, 1, 32'h308, 0, 0, 0, 0, 0, 0, 1, 0, 0, 32'h30C, 0);
    look ("nt_miss_no_fwd_next", 32'h308, 0, 0, 32'h30C, 0);

    @(posedge clk);
    #1;
    obs_valid = 1'b0;
    upd_valid_i = 1'b0;
    for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(posedge clk);
    if (exp_q.size() != 0) begin
      n_cmp++;
      n_fail++;
      $display("FAIL drain: %0d expected entries left, required 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end
endmodule
